// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample ratio and the
// start-bit mid-point used by the receiver (and reused by the transmitter).
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned START_MID  = 7;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd5
`endif
  } rx_state_e;

endpackage

// File: rtl/baud_gen.sv
// Free-running oversample tick generator.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-low reset
//   o_tick - one-clk enable every CLK_DIV clocks (registered)
module baud_gen #(
  parameter int unsigned CLK_DIV = 326
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Wrap counter at CLK_DIV-1 and flag the wrap cycle.
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == CW'(CLK_DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, glitch rejection on the start bit,
// frame-error detection and break handling.
// Optional even parity: define UART_RX_PARITY_EN.
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-low reset
//   i_rx         - serial line, idle high, asynchronous to clk
//   o_data       - last correctly framed word (LSB first on the line)
//   o_rx_valid   - one-clk pulse, o_data updated
//   o_frame_err  - one-clk pulse, stop bit sampled low
//   o_parity_err - one-clk pulse with o_rx_valid on parity mismatch
//                  (UART_RX_PARITY_EN only)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned CLK_DIV = 326,
  parameter int unsigned SB_TICK = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rx,
  output logic [N-1:0] o_data,
  output logic         o_rx_valid,
  output logic         o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic         o_parity_err
`endif
);

  localparam int unsigned SMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int unsigned SW   = $clog2(SMAX + 1);
  localparam int unsigned NW   = $clog2(N + 1);

  logic tick;

  baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .o_tick (tick)
  );

  // Two-flop synchronizer; flops reset to the idle line level.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  rx_state_e     state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          par_mis_q, par_mis_d;
  logic          perr_q, perr_d;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mis_d = par_mis_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          s_d     = '0;
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          if (s_q == SW'(START_MID)) begin
            // Still low at mid-bit: real start bit, else a glitch.
            if (!rx_s_q) begin
              s_d     = '0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[N-1:1]};
            if (n_q == NW'(N - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            s_d       = '0;
            // Even parity: data plus parity bit must XOR to zero.
            par_mis_d = ^{rx_s_q, b_q};
            state_d   = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            s_d = '0;
            if (rx_s_q) begin
              data_d  = b_q;
              valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d  = par_mis_q;
`endif
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      BREAK: begin
        // Wait for the line to return high before arming for a new start.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_mis_q <= par_mis_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_rx_valid  = valid_q;
  assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with CLK_DIV=4 (one bit = 64 clocks).
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned N        = 8;
  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned BIT_CLKS = 16 * CLK_DIV;

  logic         clk;
  logic         rst;
  logic         rx;
  logic [N-1:0] o_data;
  logic         o_rx_valid;
  logic         o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic         o_parity_err;
`endif

  uart_rx #(
    .N       (N),
    .CLK_DIV (CLK_DIV),
    .SB_TICK (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (rx),
    .o_data       (o_data),
    .o_rx_valid   (o_rx_valid),
    .o_frame_err  (o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err (o_parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Pulse monitor, sampled on the falling edge.
  int       valid_cnt   = 0;
  int       ferr_cnt    = 0;
  int       perr_cnt    = 0;
  int       overlap_cnt = 0;
  int       wide_cnt    = 0;
  logic     prev_valid  = 1'b0;
  logic     prev_ferr   = 1'b0;
  logic [7:0] rx_log [0:31];

  always @(negedge clk) begin
    if (o_rx_valid) begin
      if (valid_cnt < 32) rx_log[valid_cnt] = o_data;
      valid_cnt = valid_cnt + 1;
`ifdef UART_RX_PARITY_EN
      if (o_parity_err) perr_cnt = perr_cnt + 1;
`endif
    end
    if (o_frame_err) ferr_cnt = ferr_cnt + 1;
    if (o_rx_valid && o_frame_err) overlap_cnt = overlap_cnt + 1;
    if ((o_rx_valid && prev_valid) || (o_frame_err && prev_ferr)) wide_cnt = wide_cnt + 1;
    prev_valid = o_rx_valid;
    prev_ferr  = o_frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic hold(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic use_par, input logic par);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
    if (use_par) hold(par, BIT_CLKS);
    hold(stop_bit, BIT_CLKS);
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b0;

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_data",  32'(o_data), 32'h00);
    check("rst_valid", 32'(o_rx_valid), 32'h0);
    check("rst_ferr",  32'(o_frame_err), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_sync",  32'(dut.rx_s_q), 32'h1);
    rst = 1'b1;
    hold(1'b1, 2 * BIT_CLKS);

    // Single frame 0x55
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    hold(1'b1, BIT_CLKS);
    check("f55_cnt",  32'(valid_cnt), 32'd1);
    check("f55_log",  32'(rx_log[0]), 32'h55);
    check("f55_data", 32'(o_data), 32'h55);
    check("f55_ferr", 32'(ferr_cnt), 32'd0);

    // Back-to-back frames, single stop bit
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b0, 1'b0);
    hold(1'b1, BIT_CLKS);
    check("b2b_cnt", 32'(valid_cnt), 32'd5);
    check("b2b_0",   32'(rx_log[1]), 32'h01);
    check("b2b_1",   32'(rx_log[2]), 32'h02);
    check("b2b_2",   32'(rx_log[3]), 32'h03);
    check("b2b_3",   32'(rx_log[4]), 32'h04);

    // Framing error then break held for 40 ticks
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 40 * CLK_DIV);
    check("brk_state", 32'(dut.state_q), 32'(BREAK));
    check("brk_ferr",  32'(ferr_cnt), 32'd1);
    check("brk_valid", 32'(valid_cnt), 32'd5);
    check("brk_data",  32'(o_data), 32'h04);
    hold(1'b1, 2 * BIT_CLKS);
    check("brk_idle",  32'(dut.state_q), 32'(IDLE));
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    hold(1'b1, BIT_CLKS);
    check("f0f_cnt",  32'(valid_cnt), 32'd6);
    check("f0f_data", 32'(o_data), 32'h0F);

    // 3-tick glitch on idle line
    hold(1'b0, 3 * CLK_DIV);
    hold(1'b1, 2 * BIT_CLKS);
    check("gl_valid", 32'(valid_cnt), 32'd6);
    check("gl_ferr",  32'(ferr_cnt), 32'd1);
    check("gl_state", 32'(dut.state_q), 32'(IDLE));

    // Reset during bit 4 of 0xFF
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(1'b1, BIT_CLKS);
    hold(1'b1, 20);
    rst = 1'b0;
    hold(1'b1, 10);
    check("mr_data",  32'(o_data), 32'h00);
    check("mr_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b1;
    hold(1'b1, 4 * BIT_CLKS);
    check("mr_valid", 32'(valid_cnt), 32'd6);
    check("mr_ferr",  32'(ferr_cnt), 32'd1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    hold(1'b1, BIT_CLKS);
    check("f3c_cnt",  32'(valid_cnt), 32'd7);
    check("f3c_data", 32'(o_data), 32'h3C);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("par_ok_cnt",  32'(valid_cnt), 32'd8);
    check("par_ok_data", 32'(o_data), 32'h07);
    check("par_ok_perr", 32'(perr_cnt), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    hold(1'b1, BIT_CLKS);
    check("par_bad_cnt",  32'(valid_cnt), 32'd9);
    check("par_bad_perr", 32'(perr_cnt), 32'd1);
`endif

    // Pulse shape across the whole run
    check("overlap", 32'(overlap_cnt), 32'd0);
    check("width",   32'(wide_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter N, default 8, number of data bits per frame.
REQ-002 SHALL have parameter CLK_DIV, default 326, system clocks per oversample tick (50 MHz / (9600 baud x 16)).
REQ-003 SHALL have parameter SB_TICK, default 16, oversample ticks for the stop bit.
REQ-004 Port: clk  input  1  system clock, all logic on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: i_rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 Port: o_data  output  N  last received byte, LSB first on line.
REQ-008 Port: o_rx_valid  output  1  one-clk pulse, o_data valid; feeds the command interface's i_rx_valid.
REQ-009 Port: o_frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-010 Port: o_parity_err  output  1  one-clk pulse, parity mismatch (present only with UART_RX_PARITY_EN).

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 SHALL generate tick, a one-clk enable every CLK_DIV clocks, free-running from reset.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-014 IDLE: on rx_s==0, clear tick count, go START.
REQ-015 START: on tick count reaching 7 (mid-bit), if rx_s==0 clear count and go DATA, else return IDLE (glitch rejection, no pulse).
REQ-016 DATA: every 16 ticks sample rx_s into shift register MSB, shift right; after N samples go PARITY or STOP.
REQ-017 PARITY: after 16 ticks sample rx_s; even parity over N data bits plus parity bit; record mismatch; go STOP.
REQ-018 STOP: after SB_TICK ticks sample rx_s; high -> load o_data, pulse o_rx_valid (and o_parity_err if mismatch), go IDLE; low -> pulse o_frame_err, o_rx_valid stays 0, o_data unchanged, go BREAK.
REQ-019 BREAK: remain until rx_s==1, then IDLE; no new frame starts while line held low.
REQ-020 o_rx_valid and o_frame_err SHALL never assert in the same cycle; each pulse exactly one clk wide.
REQ-021 o_data SHALL hold its value until the next valid frame.
REQ-022 Latency: o_rx_valid asserts within 2 clk after the stop-bit mid-sample tick (synchronizer excluded).
REQ-023 Back-to-back frames with a single stop bit SHALL all be received with no loss.

Reset
REQ-024 While rst==0: state IDLE, all counters 0, shift register 0, synchronizer flops 1, o_data 0, all pulse outputs 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame without any pulse; after release, reception restarts at the next falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: frame is start, N data, even parity, stop; PARITY state and o_parity_err present.
REQ-027 Macro undefined: frame is start, N data, stop; PARITY state and o_parity_err port absent.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enumeration, OVERSAMPLE=16 and the start-bit mid-point constant 7.
REQ-029 Sub-module baud_gen (counter producing tick) SHALL be instantiated; the same block is reused by the transmitter.

Verification (bench uses CLK_DIV=4)
REQ-030 Frame 0x55, valid stop -> one o_rx_valid pulse, o_data=0x55, o_frame_err=0.
REQ-031 Frames 0x01,0x02,0x03,0x04 back-to-back -> four pulses, o_data 0x01..0x04 in order.
REQ-032 Frame 0xA3 with stop bit driven low, line held low 40 ticks then high -> one o_frame_err pulse, no o_rx_valid, o_data unchanged, next frame 0x0F received correctly.
REQ-033 Low glitch of 3 ticks on idle line -> no pulses, state returns IDLE.
REQ-034 rst low during bit 4 of frame 0xFF -> no pulses; after release frame 0x3C -> o_data=0x3C.
REQ-035 With UART_RX_PARITY_EN: 0x07 with parity 1 -> o_rx_valid, o_parity_err=0; parity 0 -> o_rx_valid with o_parity_err=1.
